// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register built as a 2-entry skid buffer (head + skid) with flush.
// Optional branch resolution at the head entry is enabled by EXMEM_BRANCH_RESOLVE_EN.
module ex_mem_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [DATA_W-1:0] branch_target_in,
    input  logic              zero_in,
    input  logic [4:0]        wreg_in,
    input  logic [5:0]        ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [DATA_W-1:0] branch_target_out,
    output logic              zero_out,
    output logic [4:0]        wreg_out,
    output logic [5:0]        ctrl_out,
    input  logic              flush,
    output logic              pc_src_out,
    output logic [1:0]        occupancy
);

    // Payload packing: {alu, store, target, zero, wreg, ctrl}, ctrl in the low bits.
    localparam int PAY_W   = 3 * DATA_W + 12;
    localparam int WREG_LO = 6;
    localparam int ZERO_B  = 11;
    localparam int BT_LO   = 12;
    localparam int ST_LO   = BT_LO + DATA_W;
    localparam int ALU_LO  = ST_LO + DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [PAY_W-1:0]   head_r;
    logic [PAY_W-1:0]   skid_r;
    logic [PAY_W-1:0]   in_pay_s;
    logic               load_head_s;
    logic               load_skid_s;
    logic               skid_to_head_s;
    logic               accept_s;
    logic               deliver_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [1:0]         occupancy_r;

    assign in_pay_s  = {alu_result_in, store_data_in, branch_target_in,
                        zero_in, wreg_in, ctrl_in};
    assign accept_s  = in_valid && in_ready_r;
    assign deliver_s = out_valid_r && out_ready;

    // Next-state and storage-steering decode; flush wins over any transfer.
    always_comb begin
        next_state_s   = state_r;
        load_head_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_head_s = 1'b0;
        if (flush) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        next_state_s = ONE;
                        load_head_s  = 1'b1;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && deliver_s) begin
                        next_state_s = ONE;
                        load_head_s  = 1'b1;
                    end else if (accept_s) begin
                        next_state_s = FULL;
                        load_skid_s  = 1'b1;
                    end else if (deliver_s) begin
                        next_state_s = EMPTY;
                    end else begin
                        next_state_s = ONE;
                    end
                end
                FULL: begin
                    if (deliver_s) begin
                        next_state_s   = ONE;
                        skid_to_head_s = 1'b1;
                    end else begin
                        next_state_s = FULL;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                end
            endcase
        end
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != FULL);
            out_valid_r <= (next_state_s != EMPTY);
            case (next_state_s)
                EMPTY:   occupancy_r <= 2'd0;
                ONE:     occupancy_r <= 2'd1;
                FULL:    occupancy_r <= 2'd2;
                default: occupancy_r <= 2'd0;
            endcase
        end
    end

    // Head and skid entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= {PAY_W{1'b0}};
            skid_r <= {PAY_W{1'b0}};
        end else begin
            if (load_head_s) begin
                head_r <= in_pay_s;
            end else if (skid_to_head_s) begin
                head_r <= skid_r;
            end else begin
                head_r <= head_r;
            end
            if (load_skid_s) begin
                skid_r <= in_pay_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready          = in_ready_r;
    assign out_valid         = out_valid_r;
    assign occupancy         = occupancy_r;
    assign alu_result_out    = head_r[ALU_LO +: DATA_W];
    assign store_data_out    = head_r[ST_LO +: DATA_W];
    assign branch_target_out = head_r[BT_LO +: DATA_W];
    assign zero_out          = head_r[ZERO_B];
    assign wreg_out          = head_r[WREG_LO +: 5];
    // Stale control bits after a flush must never look like a live instruction.
    assign ctrl_out          = out_valid_r ? head_r[5:0] : 6'd0;

`ifdef EXMEM_BRANCH_RESOLVE_EN
    assign pc_src_out = out_valid_r && (head_r[5] || (head_r[4] && head_r[ZERO_B]));
`else
    assign pc_src_out = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid with a queue scoreboard of accepted beats.
module tb_ex_mem_skid;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] bt;
        logic        z;
        logic [4:0]  w;
        logic [5:0]  c;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [31:0] branch_target_in;
    logic        zero_in;
    logic [4:0]  wreg_in;
    logic [5:0]  ctrl_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic [31:0] branch_target_out;
    logic        zero_out;
    logic [4:0]  wreg_out;
    logic [5:0]  ctrl_out;
    logic        flush;
    logic        pc_src_out;
    logic [1:0]  occupancy;

    int    checks;
    int    errors;
    int    delivered;
    beat_t q[$];

    ex_mem_skid #(.DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .alu_result_in    (alu_result_in),
        .store_data_in    (store_data_in),
        .branch_target_in (branch_target_in),
        .zero_in          (zero_in),
        .wreg_in          (wreg_in),
        .ctrl_in          (ctrl_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .alu_result_out   (alu_result_out),
        .store_data_out   (store_data_out),
        .branch_target_out(branch_target_out),
        .zero_out         (zero_out),
        .wreg_out         (wreg_out),
        .ctrl_out         (ctrl_out),
        .flush            (flush),
        .pc_src_out       (pc_src_out),
        .occupancy        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] v, input logic [5:0] c, input logic z);
        beat_t b;
        b.alu = v;
        b.st  = v ^ 32'hA5A5_0000;
        b.bt  = v + 32'h0000_0100;
        b.z   = z;
        b.w   = v[4:0];
        b.c   = c;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        alu_result_in    = b.alu;
        store_data_in    = b.st;
        branch_target_in = b.bt;
        zero_in          = b.z;
        wreg_in          = b.w;
        ctrl_in          = b.c;
    endtask

    function automatic beat_t in_beat();
        return {alu_result_in, store_data_in, branch_target_in, zero_in, wreg_in, ctrl_in};
    endfunction

    function automatic beat_t out_beat();
        return {alu_result_out, store_data_out, branch_target_out, zero_out, wreg_out, ctrl_out};
    endfunction

    // Called at a falling edge with inputs already set: score this edge, then advance one cycle.
    task automatic cycle();
        logic exp_pc;
`ifdef EXMEM_BRANCH_RESOLVE_EN
        exp_pc = out_valid && (q.size() > 0) && (q[0].c[5] || (q[0].c[4] && q[0].z));
`else
        exp_pc = 1'b0;
`endif
        chk("pc_src", pc_src_out, exp_pc);
        if (!out_valid) chk("ctrl_idle", ctrl_out, 6'd0);
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("queue_nonempty", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    chk("payload", out_beat(), q[0]);
                    void'(q.pop_front());
                    delivered++;
                end
            end
            if (in_valid && in_ready) q.push_back(in_beat());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        checks    = 0;
        errors    = 0;
        delivered = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        drive(mk(32'h0000_0000, 6'd0, 1'b0));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_pc_src", pc_src_out, 1'b0);
        chk("rst_payload", out_beat(), 108'd0);
        rst_n = 1'b1;
        chk("in_ready_before_edge", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_edge", in_ready, 1'b1);

        // Single beat, one-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(mk(32'h0000_0010, 6'b000001, 1'b0));
        cycle();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1'b1);
        chk("single_alu", alu_result_out, 32'h0000_0010);
        cycle();
        chk("single_valid_drop", out_valid, 1'b0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(mk(32'h0000_0001, 6'b000011, 1'b1));
        cycle();
        drive(mk(32'h0000_0002, 6'b001100, 1'b0));
        cycle();
        in_valid = 1'b0;
        chk("bp_occupancy_full", occupancy, 2'd2);
        chk("bp_in_ready_low", in_ready, 1'b0);
        cycle();
        chk("bp_hold_alu", alu_result_out, 32'h0000_0001);
        out_ready = 1'b1;
        chk("bp_first_alu", alu_result_out, 32'h0000_0001);
        cycle();
        chk("bp_second_alu", alu_result_out, 32'h0000_0002);
        chk("bp_in_ready_back", in_ready, 1'b1);
        chk("bp_occupancy_one", occupancy, 2'd1);
        cycle();
        chk("bp_occupancy_empty", occupancy, 2'd0);

        // Streaming 100 beats at full rate
        d0       = delivered;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(mk(32'h0000_1000 + 32'(i), 6'(i) & 6'b001111, 1'(i)));
            if (i > 0) chk("stream_occupancy", occupancy, 2'd1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_count", delivered - d0, 100);
        chk("stream_drained", q.size(), 0);

        // Flush while full, with a simultaneous offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(mk(32'h0000_0A01, 6'b100001, 1'b0));
        cycle();
        drive(mk(32'h0000_0A02, 6'b010011, 1'b1));
        cycle();
        chk("flush_pre_full", occupancy, 2'd2);
        drive(mk(32'h0000_0A03, 6'b111111, 1'b1));
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occupancy", occupancy, 2'd0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_ctrl", ctrl_out, 6'd0);
        chk("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cycle();
        chk("flush_no_ghost", out_valid, 1'b0);

        // Branch resolution at the head entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(mk(32'h0000_0B01, 6'b010000, 1'b1));
        cycle();
        in_valid = 1'b0;
`ifdef EXMEM_BRANCH_RESOLVE_EN
        chk("br_taken", pc_src_out, 1'b1);
`else
        chk("br_taken_tied", pc_src_out, 1'b0);
`endif
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b1;
        drive(mk(32'h0000_0B02, 6'b010000, 1'b0));
        cycle();
        in_valid = 1'b0;
        chk("br_not_taken", pc_src_out, 1'b0);
        in_valid = 1'b1;
        drive(mk(32'h0000_0B03, 6'b100000, 1'b0));
        cycle();
        in_valid = 1'b0;
`ifdef EXMEM_BRANCH_RESOLVE_EN
        chk("jump_taken", pc_src_out, 1'b1);
`else
        chk("jump_tied", pc_src_out, 1'b0);
`endif
        cycle();

        // Asynchronous reset while full drops both beats
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(mk(32'hDEAD_0001, 6'b000001, 1'b0));
        cycle();
        drive(mk(32'hDEAD_0002, 6'b000001, 1'b0));
        cycle();
        in_valid = 1'b0;
        chk("rstmid_pre_full", occupancy, 2'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", out_valid, 1'b0);
        chk("rstmid_occupancy", occupancy, 2'd0);
        chk("rstmid_in_ready", in_ready, 1'b0);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rstmid_no_old", out_valid, 1'b0);
        end
        d0       = delivered;
        in_valid = 1'b1;
        drive(mk(32'h0000_0C01, 6'b000010, 1'b1));
        cycle();
        in_valid = 1'b0;
        chk("rstmid_new_alu", alu_result_out, 32'h0000_0C01);
        cycle();
        chk("rstmid_new_count", delivered - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
